// File: rtl/logic_op_pkg.sv
// Shared definitions for the BinaryLogic test interface: op codes and checker FSM states.
package logic_op_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_XNOR = 3'd3;
    localparam logic [2:0] OP_NAND = 3'd4;
    localparam logic [2:0] OP_NOR  = 3'd5;
    localparam logic [2:0] OP_NOT  = 3'd6;
    localparam logic [2:0] OP_PASS = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } chk_state_e;

endpackage

// File: rtl/logic_result_checker_ref_model.sv
// Combinational reference model: recomputes the bitwise result for (op, a, b).
// Also reused by the stimulus generator, so it carries no state.
module logic_ref_model
    import logic_op_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] expected
);

    // Every 3-bit code is a defined operation; NOT and PASS only look at a.
    always_comb begin
        expected = '0;
        case (op)
            OP_AND:  expected = a & b;
            OP_OR:   expected = a | b;
            OP_XOR:  expected = a ^ b;
            OP_XNOR: expected = ~(a ^ b);
            OP_NAND: expected = ~(a & b);
            OP_NOR:  expected = ~(a | b);
            OP_NOT:  expected = ~a;
            OP_PASS: expected = a;
            default: expected = '0;
        endcase
    end

endmodule

// File: rtl/logic_result_checker.sv
// Response-side checker: accepts (a, b, op, result) tuples, compares against the
// reference model, keeps saturating pass/fail counts and captures the first mismatch.
module logic_result_checker
    import logic_op_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_last,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             err_valid,
    output logic [2:0]       err_op,
    output logic [WIDTH-1:0] err_a,
    output logic [WIDTH-1:0] err_b,
    output logic [WIDTH-1:0] err_exp,
    output logic [WIDTH-1:0] err_got
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    chk_state_e       state_q;
    logic [CNT_W-1:0] passCnt_q;
    logic [CNT_W-1:0] failCnt_q;
    logic             errValid_q;
    logic [2:0]       errOp_q;
    logic [WIDTH-1:0] errA_q;
    logic [WIDTH-1:0] errB_q;
    logic [WIDTH-1:0] errExp_q;
    logic [WIDTH-1:0] errGot_q;

    logic [WIDTH-1:0] expected;
    logic             handshake;
    logic             match;

    logic_ref_model #(.WIDTH(WIDTH)) u_ref (
        .op       (in_op),
        .a        (in_a),
        .b        (in_b),
        .expected (expected)
    );

    assign in_ready  = (state_q == ST_RUN);
    assign handshake = in_valid && in_ready;
    assign match     = (expected == in_result);

    // FSM, saturating counters and first-mismatch capture, all updated on one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            passCnt_q  <= '0;
            failCnt_q  <= '0;
            errValid_q <= 1'b0;
            errOp_q    <= '0;
            errA_q     <= '0;
            errB_q     <= '0;
            errExp_q   <= '0;
            errGot_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q    <= ST_RUN;
                        passCnt_q  <= '0;
                        failCnt_q  <= '0;
                        errValid_q <= 1'b0;
                        errOp_q    <= '0;
                        errA_q     <= '0;
                        errB_q     <= '0;
                        errExp_q   <= '0;
                        errGot_q   <= '0;
                    end
                end
                ST_RUN: begin
                    if (handshake) begin
                        if (match) begin
                            if (passCnt_q != CNT_MAX) passCnt_q <= passCnt_q + 1'b1;
                        end else begin
                            if (failCnt_q != CNT_MAX) failCnt_q <= failCnt_q + 1'b1;
                            if (!errValid_q) begin
                                errValid_q <= 1'b1;
                                errOp_q    <= in_op;
                                errA_q     <= in_a;
                                errB_q     <= in_b;
                                errExp_q   <= expected;
                                errGot_q   <= in_result;
                            end
                        end
                        if (in_last) state_q <= ST_DONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign pass_cnt  = passCnt_q;
    assign fail_cnt  = failCnt_q;
    assign err_valid = errValid_q;
    assign err_op    = errOp_q;
    assign err_a     = errA_q;
    assign err_b     = errB_q;
    assign err_exp   = errExp_q;
    assign err_got   = errGot_q;

endmodule

// File: tb/tb_logic_result_checker.sv
// Directed bench for logic_result_checker: a default instance plus a CNT_W=2
// instance sharing the same stimulus to exercise counter saturation.
module tb_logic_result_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       in_valid;
    logic [2:0] in_op;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [3:0] in_result;
    logic       in_last;

    logic        in_ready, busy, done, err_valid;
    logic [15:0] pass_cnt, fail_cnt;
    logic [2:0]  err_op;
    logic [3:0]  err_a, err_b, err_exp, err_got;

    logic        in_ready2, busy2, done2, err_valid2;
    logic [1:0]  pass_cnt2, fail_cnt2;
    logic [2:0]  err_op2;
    logic [3:0]  err_a2, err_b2, err_exp2, err_got2;

    int vectors     = 0;
    int miscompares = 0;

    logic [3:0] sweepExp [8] = '{4'h8, 4'hE, 4'h6, 4'h9, 4'h7, 4'h1, 4'h3, 4'hC};

    logic_result_checker #(.WIDTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .in_result(in_result), .in_last(in_last), .busy(busy), .done(done),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .err_valid(err_valid),
        .err_op(err_op), .err_a(err_a), .err_b(err_b), .err_exp(err_exp),
        .err_got(err_got)
    );

    logic_result_checker #(.WIDTH(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready2), .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .in_result(in_result), .in_last(in_last), .busy(busy2), .done(done2),
        .pass_cnt(pass_cnt2), .fail_cnt(fail_cnt2), .err_valid(err_valid2),
        .err_op(err_op2), .err_a(err_a2), .err_b(err_b2), .err_exp(err_exp2),
        .err_got(err_got2)
    );

    always #5 clk = ~clk;

    // One comparison point: counts the vector and reports any miscompare.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Presents one tuple for a single clock edge, then drops in_valid.
    task automatic applyStimulus(input logic [2:0] op, input logic [3:0] a,
                                 input logic [3:0] b, input logic [3:0] res,
                                 input logic last);
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_result = res;
        in_last   = last;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
    endtask

    // Pulses start for one edge.
    task automatic pulseStart();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_op = '0;
        in_a = '0; in_b = '0; in_result = '0; in_last = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ready", 32'(in_ready), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_pass", 32'(pass_cnt), 0);
        checkOutput("rst_errv", 32'(err_valid), 0);
        rst_n = 1'b1;
        #1;

        // valid held in IDLE is ignored
        in_op = 3'd3; in_a = 4'hA; in_b = 4'hA; in_result = 4'hF; in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("idle_ready", 32'(in_ready), 0);
        checkOutput("idle_busy", 32'(busy), 0);
        checkOutput("idle_pass", 32'(pass_cnt), 0);
        in_valid = 1'b0;

        // test 1: single passing XNOR with last
        pulseStart();
        checkOutput("t1_busy", 32'(busy), 1);
        checkOutput("t1_ready", 32'(in_ready), 1);
        applyStimulus(3'd3, 4'b1010, 4'b1010, 4'b1111, 1'b1);
        checkOutput("t1_pass", 32'(pass_cnt), 1);
        checkOutput("t1_fail", 32'(fail_cnt), 0);
        checkOutput("t1_done", 32'(done), 1);
        checkOutput("t1_busy_end", 32'(busy), 0);
        checkOutput("t1_ready_end", 32'(in_ready), 0);
        checkOutput("t1_errv", 32'(err_valid), 0);

        // test 2: one pass, then a mismatch captured as first error
        pulseStart();
        checkOutput("t2_clr_pass", 32'(pass_cnt), 0);
        applyStimulus(3'd3, 4'b0111, 4'b1001, 4'b0001, 1'b0);
        checkOutput("t2_pass1", 32'(pass_cnt), 1);
        applyStimulus(3'd3, 4'b0111, 4'b1001, 4'b0000, 1'b1);
        checkOutput("t2_pass", 32'(pass_cnt), 1);
        checkOutput("t2_fail", 32'(fail_cnt), 1);
        checkOutput("t2_errv", 32'(err_valid), 1);
        checkOutput("t2_errop", 32'(err_op), 3);
        checkOutput("t2_erra", 32'(err_a), 32'h7);
        checkOutput("t2_errb", 32'(err_b), 32'h9);
        checkOutput("t2_errexp", 32'(err_exp), 32'h1);
        checkOutput("t2_errgot", 32'(err_got), 32'h0);
        checkOutput("t2_done", 32'(done), 1);

        // test 3: sweep all ops with correct results
        pulseStart();
        checkOutput("t3_clr_errv", 32'(err_valid), 0);
        checkOutput("t3_clr_fail", 32'(fail_cnt), 0);
        checkOutput("t3_clr_errexp", 32'(err_exp), 0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(3'(i), 4'b1100, 4'b1010, sweepExp[i], (i == 7));
        end
        checkOutput("t3_pass", 32'(pass_cnt), 8);
        checkOutput("t3_fail", 32'(fail_cnt), 0);
        checkOutput("t3_done", 32'(done), 1);

        // test 4: valid held in DONE is ignored; start in RUN does not clear
        in_op = 3'd0; in_a = 4'hC; in_b = 4'hA; in_result = 4'h0; in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("t4_done_ready", 32'(in_ready), 0);
        checkOutput("t4_done_pass", 32'(pass_cnt), 8);
        checkOutput("t4_done_fail", 32'(fail_cnt), 0);
        in_valid = 1'b0;
        pulseStart();
        applyStimulus(3'd0, 4'hC, 4'hA, 4'h8, 1'b0);
        checkOutput("t4_pass1", 32'(pass_cnt), 1);
        pulseStart();
        checkOutput("t4_run_start_pass", 32'(pass_cnt), 1);
        checkOutput("t4_run_start_busy", 32'(busy), 1);
        applyStimulus(3'd0, 4'hC, 4'hA, 4'h0, 1'b1);
        checkOutput("t4_fail", 32'(fail_cnt), 1);
        checkOutput("t4_errexp", 32'(err_exp), 32'h8);
        checkOutput("t4_done", 32'(done), 1);

        // test 5: CNT_W=2 instance saturates at 3
        pulseStart();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(3'd7, 4'h5, 4'h0, 4'h5, 1'b0);
            checkOutput("t5_pass2", 32'(pass_cnt2), (i < 3) ? i + 1 : 3);
        end
        checkOutput("t5_pass16", 32'(pass_cnt), 5);
        checkOutput("t5_busy2", 32'(busy2), 1);
        applyStimulus(3'd7, 4'h5, 4'h0, 4'h0, 1'b1);
        checkOutput("t5_fail2", 32'(fail_cnt2), 1);
        checkOutput("t5_errv2", 32'(err_valid2), 1);
        checkOutput("t5_errgot2", 32'(err_got2), 0);
        checkOutput("t5_erra2", 32'(err_a2), 32'h5);
        pulseStart();
        checkOutput("t5_clr_pass2", 32'(pass_cnt2), 0);
        checkOutput("t5_clr_fail2", 32'(fail_cnt2), 0);
        checkOutput("t5_clr_errv2", 32'(err_valid2), 0);
        checkOutput("t5_clr_erra2", 32'(err_a2), 0);

        // test 6a: async reset between handshakes
        applyStimulus(3'd1, 4'h3, 4'h0, 4'h3, 1'b0);
        checkOutput("t6_pre_pass", 32'(pass_cnt), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6a_pass", 32'(pass_cnt), 0);
        checkOutput("t6a_busy", 32'(busy), 0);
        checkOutput("t6a_ready", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("t6a_idle_busy", 32'(busy), 0);
        checkOutput("t6a_idle_done", 32'(done), 0);

        // test 6b: async reset while a mismatching tuple is being offered
        pulseStart();
        in_op = 3'd2; in_a = 4'hF; in_b = 4'h0; in_result = 4'h0; in_last = 1'b0;
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6b_fail", 32'(fail_cnt), 0);
        checkOutput("t6b_errv", 32'(err_valid), 0);
        checkOutput("t6b_ready", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        checkOutput("t6b_hold_fail", 32'(fail_cnt), 0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("t6b_idle_busy", 32'(busy), 0);
        checkOutput("t6b_idle_pass", 32'(pass_cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
